// File: rtl/dma_bus_arbiter.sv
// Hands the system bus between the CPU core and a DMA master via a BUSRQ/BUSAK handshake.
// Grants are capped at MAXHOLD writes, after which the CPU gets the bus back for a CPU_SLOT window.
module dma_bus_arbiter #(
    parameter int MAXHOLD  = 256,
    parameter int CPU_SLOT = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dma_busrq_n,
    output logic        dma_busak_n,
    output logic        cpu_busrq_n,
    input  logic        cpu_busak_n,
    input  logic [15:0] cpu_a,
    input  logic [7:0]  cpu_dout,
    input  logic        cpu_mreq_n,
    input  logic        cpu_iorq_n,
    input  logic        cpu_rd_n,
    input  logic        cpu_wr_n,
    input  logic [15:0] dma_a,
    input  logic [7:0]  dma_dout,
    input  logic        dma_mreq_n,
    input  logic        dma_iorq_n,
    input  logic        dma_rd_n,
    input  logic        dma_wr_n,
    output logic [15:0] bus_a,
    output logic [7:0]  bus_dout,
    output logic        bus_mreq_n,
    output logic        bus_iorq_n,
    output logic        bus_rd_n,
    output logic        bus_wr_n,
    output logic        dma_owner
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_REQ     = 3'd1;
    localparam logic [2:0] S_SWITCH  = 3'd2;
    localparam logic [2:0] S_GRANT   = 3'd3;
    localparam logic [2:0] S_RELEASE = 3'd4;
    localparam logic [2:0] S_YIELD   = 3'd5;

    // The hold counter saturates at FFFFh, so any larger limit simply never triggers.
    localparam logic [16:0] HOLD_LIMIT = (MAXHOLD > 65536) ? 17'h10000 : 17'(MAXHOLD);
    localparam logic [7:0]  SLOT_INIT  = 8'(CPU_SLOT);

    logic [2:0]  state_q, state_d;
    logic        cpu_busrq_n_q, cpu_busrq_n_d;
    logic        dma_busak_n_q, dma_busak_n_d;
    logic        dma_owner_q, dma_owner_d;
    logic [15:0] hold_q, hold_d;
    logic [7:0]  slot_q, slot_d;
    logic        forced_q, forced_d;
    logic        wr_prev_q;

    logic dma_idle;
    logic wr_rise;
    logic hold_limit;

    assign dma_idle   = dma_mreq_n & dma_iorq_n & dma_rd_n & dma_wr_n;
    assign wr_rise    = ~wr_prev_q & dma_wr_n;
    assign hold_limit = (MAXHOLD != 0) && ({1'b0, hold_q} >= HOLD_LIMIT);

    always_comb begin
        // NOTE: every next-state signal gets its hold value first, so no branch can infer a latch.
        state_d       = state_q;
        cpu_busrq_n_d = cpu_busrq_n_q;
        dma_busak_n_d = dma_busak_n_q;
        dma_owner_d   = dma_owner_q;
        hold_d        = hold_q;
        slot_d        = slot_q;
        forced_d      = forced_q;

        case (state_q)
            S_IDLE: begin
                if (!dma_busrq_n) begin
                    state_d       = S_REQ;
                    cpu_busrq_n_d = 1'b0;
                end
            end
            S_REQ: begin
                // A withdrawn request wins over a simultaneous CPU acknowledge.
                if (dma_busrq_n) begin
                    state_d       = S_IDLE;
                    cpu_busrq_n_d = 1'b1;
                end else if (!cpu_busak_n) begin
                    state_d     = S_SWITCH;
                    dma_owner_d = 1'b1;
                end
            end
            S_SWITCH: begin
                state_d       = S_GRANT;
                dma_busak_n_d = 1'b0;
                hold_d        = '0;
            end
            S_GRANT: begin
                if (wr_rise && hold_q != 16'hFFFF) begin
                    hold_d = hold_q + 16'd1;
                end
                // cpu_busak_n is deliberately not looked at here.
                if (dma_busrq_n) begin
                    state_d       = S_RELEASE;
                    dma_busak_n_d = 1'b1;
                    forced_d      = 1'b0;
                end else if (hold_limit && dma_idle) begin
                    state_d       = S_RELEASE;
                    dma_busak_n_d = 1'b1;
                    forced_d      = 1'b1;
                end
            end
            S_RELEASE: begin
                if (dma_idle) begin
                    dma_owner_d   = 1'b0;
                    cpu_busrq_n_d = 1'b1;
                    if (forced_q) begin
                        state_d = S_YIELD;
                        slot_d  = SLOT_INIT;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_YIELD: begin
                if (slot_q == 8'd0) begin
                    state_d = S_IDLE;
                end else begin
                    slot_d = slot_q - 8'd1;
                end
            end
            default: begin
                state_d       = S_IDLE;
                cpu_busrq_n_d = 1'b1;
                dma_busak_n_d = 1'b1;
                dma_owner_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst_n) begin
            state_q       <= S_IDLE;
            cpu_busrq_n_q <= 1'b1;
            dma_busak_n_q <= 1'b1;
            dma_owner_q   <= 1'b0;
            hold_q        <= '0;
            slot_q        <= '0;
            forced_q      <= 1'b0;
            wr_prev_q     <= 1'b1;
        end else begin
            state_q       <= state_d;
            cpu_busrq_n_q <= cpu_busrq_n_d;
            dma_busak_n_q <= dma_busak_n_d;
            dma_owner_q   <= dma_owner_d;
            hold_q        <= hold_d;
            slot_q        <= slot_d;
            forced_q      <= forced_d;
            wr_prev_q     <= dma_wr_n;
        end
    end

    assign dma_busak_n = dma_busak_n_q;
    assign cpu_busrq_n = cpu_busrq_n_q;
    assign dma_owner   = dma_owner_q;

    // The data path switches combinationally; only the ownership flag is registered.
    assign bus_a      = dma_owner_q ? dma_a      : cpu_a;
    assign bus_dout   = dma_owner_q ? dma_dout   : cpu_dout;
    assign bus_mreq_n = dma_owner_q ? dma_mreq_n : cpu_mreq_n;
    assign bus_iorq_n = dma_owner_q ? dma_iorq_n : cpu_iorq_n;
    assign bus_rd_n   = dma_owner_q ? dma_rd_n   : cpu_rd_n;
    assign bus_wr_n   = dma_owner_q ? dma_wr_n   : cpu_wr_n;

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// Self-checking bench for dma_bus_arbiter: directed handshake scenarios followed by random traffic,
// compared every clock against a phase-level reference model.
module tb_dma_bus_arbiter;

    localparam int MAXHOLD  = 4;
    localparam int CPU_SLOT = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        dma_busrq_n, dma_busak_n, cpu_busrq_n, cpu_busak_n;
    logic [15:0] cpu_a, dma_a, bus_a;
    logic [7:0]  cpu_dout, dma_dout, bus_dout;
    logic        cpu_mreq_n, cpu_iorq_n, cpu_rd_n, cpu_wr_n;
    logic        dma_mreq_n, dma_iorq_n, dma_rd_n, dma_wr_n;
    logic        bus_mreq_n, bus_iorq_n, bus_rd_n, bus_wr_n;
    logic        dma_owner;

    int n_checks = 0;
    int n_fail   = 0;
    bit auto_ack = 1'b0;

    dma_bus_arbiter #(.MAXHOLD(MAXHOLD), .CPU_SLOT(CPU_SLOT)) dut (
        .clk(clk), .rst_n(rst_n),
        .dma_busrq_n(dma_busrq_n), .dma_busak_n(dma_busak_n),
        .cpu_busrq_n(cpu_busrq_n), .cpu_busak_n(cpu_busak_n),
        .cpu_a(cpu_a), .cpu_dout(cpu_dout),
        .cpu_mreq_n(cpu_mreq_n), .cpu_iorq_n(cpu_iorq_n), .cpu_rd_n(cpu_rd_n), .cpu_wr_n(cpu_wr_n),
        .dma_a(dma_a), .dma_dout(dma_dout),
        .dma_mreq_n(dma_mreq_n), .dma_iorq_n(dma_iorq_n), .dma_rd_n(dma_rd_n), .dma_wr_n(dma_wr_n),
        .bus_a(bus_a), .bus_dout(bus_dout),
        .bus_mreq_n(bus_mreq_n), .bus_iorq_n(bus_iorq_n), .bus_rd_n(bus_rd_n), .bus_wr_n(bus_wr_n),
        .dma_owner(dma_owner)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: which phase of the bus handover we are in, plus transfer and slot tallies.
    typedef enum {P_IDLE, P_REQ, P_SWITCH, P_GRANT, P_RELEASE, P_YIELD} phase_t;
    phase_t ph = P_IDLE;
    int     xfers = 0;
    int     slot_left = 0;
    bit     forced = 1'b0;
    bit     wr_prev = 1'b1;

    task automatic model_step();
        bit idle;
        bit rise;
        idle = dma_mreq_n && dma_iorq_n && dma_rd_n && dma_wr_n;
        rise = !wr_prev && dma_wr_n;
        if (!rst_n) begin
            ph = P_IDLE; xfers = 0; slot_left = 0; forced = 1'b0; wr_prev = 1'b1;
            return;
        end
        wr_prev = dma_wr_n;
        case (ph)
            P_IDLE:   if (!dma_busrq_n) ph = P_REQ;
            P_REQ:    if (dma_busrq_n) ph = P_IDLE; else if (!cpu_busak_n) ph = P_SWITCH;
            P_SWITCH: begin ph = P_GRANT; xfers = 0; end
            P_GRANT: begin
                if (dma_busrq_n) begin
                    ph = P_RELEASE; forced = 1'b0;
                end else if (MAXHOLD != 0 && xfers >= MAXHOLD && idle) begin
                    ph = P_RELEASE; forced = 1'b1;
                end
                if (rise && xfers < 65535) xfers++;
            end
            P_RELEASE: if (idle) begin
                if (forced) begin ph = P_YIELD; slot_left = CPU_SLOT; end
                else ph = P_IDLE;
            end
            P_YIELD: if (slot_left == 0) ph = P_IDLE; else slot_left--;
            default: ph = P_IDLE;
        endcase
    endtask

    task automatic compare_outputs();
        bit own;
        logic [27:0] exp_bus, got_bus;
        own = ph inside {P_SWITCH, P_GRANT, P_RELEASE};
        check("dma_busak_n", 32'(dma_busak_n), 32'(ph != P_GRANT));
        check("cpu_busrq_n", 32'(cpu_busrq_n), 32'(ph inside {P_IDLE, P_YIELD}));
        check("dma_owner", 32'(dma_owner), 32'(own));
        got_bus = {bus_a, bus_dout, bus_mreq_n, bus_iorq_n, bus_rd_n, bus_wr_n};
        exp_bus = own ? {dma_a, dma_dout, dma_mreq_n, dma_iorq_n, dma_rd_n, dma_wr_n}
                      : {cpu_a, cpu_dout, cpu_mreq_n, cpu_iorq_n, cpu_rd_n, cpu_wr_n};
        check("bus_mux", 32'(got_bus), 32'(exp_bus));
    endtask

    // Inputs change only at the falling edge; the model advances on the rising edge.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_outputs();
    endtask

    task automatic randomize_data();
        cpu_a    = 16'($urandom);
        dma_a    = 16'($urandom);
        cpu_dout = 8'($urandom);
        dma_dout = 8'($urandom);
        {cpu_mreq_n, cpu_iorq_n, cpu_rd_n, cpu_wr_n} = 4'($urandom);
    endtask

    // strb packs {mreq, iorq, rd, wr}, all active low.
    task automatic step(input logic rq, input logic [3:0] strb);
        dma_busrq_n = rq;
        {dma_mreq_n, dma_iorq_n, dma_rd_n, dma_wr_n} = strb;
        randomize_data();
        if (auto_ack) cpu_busak_n = cpu_busrq_n;
        tick();
    endtask

    task automatic do_writes(input int n);
        repeat (n) begin
            step(1'b0, 4'b1110);
            step(1'b0, 4'b1111);
        end
    endtask

    task automatic get_grant();
        for (int i = 0; i < 30 && dma_busak_n; i++) step(1'b0, 4'b1111);
        check("grant_reached", 32'(dma_busak_n), 32'd0);
    endtask

    initial begin
        int lat;
        int gap;
        rst_n = 1'b0;
        cpu_busak_n = 1'b1;
        dma_busrq_n = 1'b1;
        {dma_mreq_n, dma_iorq_n, dma_rd_n, dma_wr_n} = 4'hF;
        randomize_data();
        tick();
        tick();
        rst_n = 1'b1;

        // Request withdrawn before the CPU acknowledges.
        step(1'b0, 4'hF);
        step(1'b1, 4'hF);
        check("withdraw_busrq", 32'(cpu_busrq_n), 32'd1);
        check("withdraw_owner", 32'(dma_owner), 32'd0);

        // Burst grant latency from the acknowledge sample.
        auto_ack = 1'b1;
        step(1'b0, 4'hF);
        lat = 0;
        do begin
            step(1'b0, 4'hF);
            lat++;
        end while (dma_busak_n && lat < 8);
        check("grant_latency", 32'(lat), 32'd2);
        check("burst_bus_a", 32'(bus_a), 32'(dma_a));

        // Forced yield after MAXHOLD write completions, then re-grant.
        do_writes(MAXHOLD);
        step(1'b0, 4'hF);
        check("yield_busak", 32'(dma_busak_n), 32'd1);
        gap = 0;
        for (int i = 0; i < 40; i++) begin
            step(1'b0, 4'hF);
            if (!dma_owner) gap++;
            if (!dma_busak_n) break;
        end
        check("yield_gap_min", 32'(gap >= CPU_SLOT), 32'd1);
        check("regrant", 32'(dma_busak_n), 32'd0);

        // Limit reached while a read is in flight: grant is kept until strobes go idle.
        do_writes(MAXHOLD);
        repeat (3) step(1'b0, 4'b1101);
        check("guard_busak", 32'(dma_busak_n), 32'd0);
        step(1'b0, 4'hF);
        check("guard_release", 32'(dma_busak_n), 32'd1);
        get_grant();

        // Request removal coinciding with the hold limit returns to IDLE, not YIELD.
        do_writes(MAXHOLD);
        step(1'b1, 4'hF);
        step(1'b1, 4'hF);
        step(1'b0, 4'hF);
        check("no_yield_rereq", 32'(cpu_busrq_n), 32'd0);

        // Reset in the middle of a DMA write.
        get_grant();
        step(1'b0, 4'b1110);
        rst_n = 1'b0;
        step(1'b0, 4'b1110);
        rst_n = 1'b1;
        check("rst_owner", 32'(dma_owner), 32'd0);
        check("rst_busak", 32'(dma_busak_n), 32'd1);
        check("rst_bus_wr", 32'(bus_wr_n), 32'(cpu_wr_n));

        // Random traffic, including protocol-violating acknowledges and occasional resets.
        auto_ack = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 29) == 0) dma_busrq_n = ~dma_busrq_n;
            dma_mreq_n  = ($urandom_range(0, 3) != 0);
            dma_iorq_n  = ($urandom_range(0, 3) != 0);
            dma_rd_n    = ($urandom_range(0, 3) != 0);
            dma_wr_n    = ($urandom_range(0, 2) != 0);
            cpu_busak_n = cpu_busrq_n ^ ($urandom_range(0, 9) == 0);
            rst_n       = ($urandom_range(0, 299) != 0);
            randomize_data();
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dma_bus_arbiter.md
DMA_BUS_ARBITER -- requirements
Module: dma_bus_arbiter

Interface
REQ-001 SHALL have parameter MAXHOLD, default 256, meaning DMA transfers allowed per grant before forced yield; 0 disables yield.
REQ-002 SHALL have parameter CPU_SLOT, default 8, meaning clocks the bus is returned to the CPU during a forced yield (1..255).
REQ-003 SHALL have ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- dma_busrq_n  in  1  bus request from DMA master, active low.
- dma_busak_n  out  1  bus grant to DMA master, active low.
- cpu_busrq_n  out  1  bus request to CPU core, active low.
- cpu_busak_n  in  1  bus acknowledge from CPU core, active low.
- cpu_a  in  16  CPU address.
- cpu_dout  in  8  CPU write data.
- cpu_mreq_n, cpu_iorq_n, cpu_rd_n, cpu_wr_n  in  1 each  CPU strobes.
- dma_a  in  16  DMA address.
- dma_dout  in  8  DMA write data.
- dma_mreq_n, dma_iorq_n, dma_rd_n, dma_wr_n  in  1 each  DMA strobes.
- bus_a  out  16  system address.
- bus_dout  out  8  system write data.
- bus_mreq_n, bus_iorq_n, bus_rd_n, bus_wr_n  out  1 each  system strobes.
- dma_owner  out  1  1 = DMA drives the system bus.

Function
REQ-004 SHALL drive bus_a, bus_dout and bus strobes combinationally from the DMA inputs when dma_owner=1, else from the CPU inputs.
REQ-005 SHALL implement states IDLE, REQ, SWITCH, GRANT, RELEASE, YIELD; dma_owner and dma_busak_n registered.
REQ-006 IDLE: cpu_busrq_n=1, dma_busak_n=1, dma_owner=0; dma_busrq_n=0 -> REQ with cpu_busrq_n<=0.
REQ-007 REQ: hold cpu_busrq_n=0; cpu_busak_n=0 -> SWITCH with dma_owner<=1; dma_busrq_n=1 before ack -> IDLE with cpu_busrq_n<=1.
REQ-008 SWITCH: one clock mux settle; -> GRANT with dma_busak_n<=0 and hold counter cleared.
REQ-009 GRANT: hold counter (16-bit, saturating at FFFFh) increments on each dma_wr_n 0->1 edge (previous-cycle register).
REQ-010 GRANT -> RELEASE when dma_busrq_n=1, or when MAXHOLD!=0, count>=MAXHOLD and all four DMA strobes are 1; on entry dma_busak_n<=1.
REQ-011 Forced revoke SHALL NOT occur while any DMA strobe is 0; it waits for the strobes-idle cycle.
REQ-012 RELEASE: wait until all DMA strobes are 1, then dma_owner<=0, cpu_busrq_n<=1; -> IDLE if the exit cause was request removal, -> YIELD if forced.
REQ-013 If dma_busrq_n=1 and forced-revoke condition coincide in the same cycle, request removal wins (RELEASE -> IDLE, no yield).
REQ-014 YIELD: slot counter loaded with CPU_SLOT, decrements each clock with cpu_busrq_n=1; at 0 -> IDLE (re-arbitration from IDLE if dma_busrq_n still 0).
REQ-015 Latency: dma_busrq_n falling to dma_busak_n falling SHALL be exactly 2 clocks after the cpu_busak_n=0 sample (REQ->SWITCH->GRANT).
REQ-016 dma_busak_n SHALL never be 0 while dma_owner=0; dma_owner SHALL never be 1 while cpu_busak_n was 1 at the REQ exit sample.
REQ-017 cpu_busak_n returning to 1 while in GRANT (protocol violation) SHALL be ignored until RELEASE completes.

Reset
REQ-018 On rst_n=0 at a clock edge: state IDLE, dma_busak_n=1, cpu_busrq_n=1, dma_owner=0, hold and slot counters 0, edge register 1.
REQ-019 Reset mid-GRANT SHALL return the bus to the CPU on the next edge regardless of DMA strobe state.

Verification
REQ-020 Burst: dma_busrq_n=0, cpu_busak_n=0 one clock after cpu_busrq_n=0 -> dma_busak_n=0 two clocks later, bus_a follows dma_a.
REQ-021 Forced yield: MAXHOLD=4, CPU_SLOT=8, DMA continuous transfers -> dma_busak_n=1 after 4th dma_wr_n rise, dma_owner=0 for >=8 clocks, then re-grant.
REQ-022 Strobe guard: count reaches MAXHOLD while dma_rd_n=0 -> dma_busak_n stays 0 until strobes idle.
REQ-023 Request withdrawn in REQ before cpu_busak_n=0 -> cpu_busrq_n=1 next clock, dma_owner never 1.
REQ-024 Simultaneous dma_busrq_n=1 and count=MAXHOLD -> state RELEASE then IDLE, no YIELD.
REQ-025 rst_n=0 during GRANT with dma_wr_n=0 -> next edge dma_owner=0, dma_busak_n=1, bus strobes follow CPU.
